// File: rtl/semaforo_controlador.sv
// Three-approach traffic light controller: timed green/yellow phases with
// minimum/maximum green and round-robin service of the A/B/C vehicle sensors.
module semaforo_controlador #(
   parameter int unsigned T_VERDE_MIN = 4,
   parameter int unsigned T_VERDE_MAX = 8,
   parameter int unsigned T_AMARELO   = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] ABC,
   output logic       VDA,
   output logic       VAA,
   output logic       VMA,
   output logic       VDB,
   output logic       VAB,
   output logic       VMB,
   output logic       VDC,
   output logic       VAC,
   output logic       VMC,
   output logic [1:0] fase
);

   // Counter must also reach T_AMARELO-1 if yellow is configured longer than max green
   localparam int unsigned T_CMAX = (T_VERDE_MAX > T_AMARELO) ? T_VERDE_MAX : T_AMARELO;
   localparam int unsigned CW     = (T_CMAX > 1) ? $clog2(T_CMAX + 1) : 1;
   localparam int unsigned OW     = 11;

   localparam logic [CW-1:0] C_MIN = CW'(T_VERDE_MIN - 1);
   localparam logic [CW-1:0] C_MAX = CW'(T_VERDE_MAX - 1);
   localparam logic [CW-1:0] C_AM  = CW'(T_AMARELO - 1);

   localparam logic [1:0] AP_A = 2'd0;
   localparam logic [1:0] AP_B = 2'd1;
   localparam logic [1:0] AP_C = 2'd2;

   // State encoding is {approach, yellow}
   localparam logic [2:0] S_VERDE_A   = 3'b000;
   localparam logic [2:0] S_AMARELO_A = 3'b001;
   localparam logic [2:0] S_VERDE_B   = 3'b010;
   localparam logic [2:0] S_AMARELO_B = 3'b011;
   localparam logic [2:0] S_VERDE_C   = 3'b100;
   localparam logic [2:0] S_AMARELO_C = 3'b101;

   // Lamp vector {VDA,VAA,VMA, VDB,VAB,VMB, VDC,VAC,VMC, fase}
   localparam logic [OW-1:0] OUT_RST = {3'b100, 3'b001, 3'b001, 2'b00};

   logic [2:0]    r_state;
   logic [CW-1:0] r_cont;
   logic [1:0]    r_prox;
   logic [OW-1:0] r_out;

   logic [2:0]    w_next_state;
   logic [CW-1:0] w_next_cont;
   logic [1:0]    w_next_prox;
   logic [OW-1:0] w_next_out;
   logic [1:0]    w_srv;
   logic          w_own;
   logic          w_outros;
   logic [1:0]    w_rr;
   logic          w_exit;

   // Sensor view relative to the served approach and round-robin pick
   always_comb begin
      w_srv    = r_state[2:1];
      w_own    = 1'b0;
      w_outros = 1'b0;
      w_rr     = AP_A;
      case (w_srv)
         AP_A: begin
            w_own    = ABC[2];
            w_outros = ABC[1] | ABC[0];
            w_rr     = ABC[1] ? AP_B : AP_C;
         end
         AP_B: begin
            w_own    = ABC[1];
            w_outros = ABC[0] | ABC[2];
            w_rr     = ABC[0] ? AP_C : AP_A;
         end
         AP_C: begin
            w_own    = ABC[0];
            w_outros = ABC[2] | ABC[1];
            w_rr     = ABC[2] ? AP_A : AP_B;
         end
         default: begin
            w_own    = 1'b0;
            w_outros = 1'b0;
            w_rr     = AP_A;
         end
      endcase
      w_exit = (r_cont >= C_MIN) && w_outros && (!w_own || (r_cont >= C_MAX));
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      w_next_cont  = r_cont;
      w_next_prox  = r_prox;
      case (r_state)
         S_VERDE_A, S_VERDE_B, S_VERDE_C: begin
            if (w_exit) begin
               w_next_state = {w_srv, 1'b1};
               w_next_cont  = '0;
               w_next_prox  = w_rr;
            end else if (r_cont < C_MAX) begin
               w_next_cont = r_cont + CW'(1);
            end
         end
         S_AMARELO_A, S_AMARELO_B, S_AMARELO_C: begin
            if (r_cont >= C_AM) begin
               w_next_state = (r_prox == 2'd3) ? S_VERDE_A : {r_prox, 1'b0};
               w_next_cont  = '0;
            end else begin
               w_next_cont = r_cont + CW'(1);
            end
         end
         default: begin
            w_next_state = S_VERDE_A;
            w_next_cont  = '0;
            w_next_prox  = AP_A;
         end
      endcase
   end

   // Moore lamp decode of the upcoming state, registered alongside it
   always_comb begin
      w_next_out = {3'b001, 3'b001, 3'b001, 2'b00};
      case (w_next_state[2:1])
         AP_A: begin
            w_next_out[10:8] = w_next_state[0] ? 3'b010 : 3'b100;
            w_next_out[1:0]  = AP_A;
         end
         AP_B: begin
            w_next_out[7:5] = w_next_state[0] ? 3'b010 : 3'b100;
            w_next_out[1:0] = AP_B;
         end
         AP_C: begin
            w_next_out[4:2] = w_next_state[0] ? 3'b010 : 3'b100;
            w_next_out[1:0] = AP_C;
         end
         default: w_next_out = OUT_RST;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= S_VERDE_A;
         r_cont  <= '0;
         r_prox  <= AP_A;
         r_out   <= OUT_RST;
      end else begin
         r_state <= w_next_state;
         r_cont  <= w_next_cont;
         r_prox  <= w_next_prox;
         r_out   <= w_next_out;
      end
   end

   assign VDA  = r_out[10];
   assign VAA  = r_out[9];
   assign VMA  = r_out[8];
   assign VDB  = r_out[7];
   assign VAB  = r_out[6];
   assign VMB  = r_out[5];
   assign VDC  = r_out[4];
   assign VAC  = r_out[3];
   assign VMC  = r_out[2];
   assign fase = r_out[1:0];

endmodule

// File: tb/tb_semaforo_controlador.sv
// Bench for semaforo_controlador: phase-level reference model compared every
// cycle, plus hand-computed lamp patterns at the key cycles of each scenario.
module tb_semaforo_controlador;

   localparam int MINV = 4;
   localparam int MAXV = 8;
   localparam int AM   = 2;

   // {VDA,VAA,VMA, VDB,VAB,VMB, VDC,VAC,VMC, fase}
   localparam logic [10:0] AG = 11'b100_001_001_00;
   localparam logic [10:0] AY = 11'b010_001_001_00;
   localparam logic [10:0] BG = 11'b001_100_001_01;
   localparam logic [10:0] BY = 11'b001_010_001_01;
   localparam logic [10:0] CG = 11'b001_001_100_10;

   logic       clock;
   logic       reset;
   logic [2:0] ABC;
   logic VDA, VAA, VMA, VDB, VAB, VMB, VDC, VAC, VMC;
   logic [1:0] fase;
   logic [10:0] dut_v;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model: served approach, yellow flag, cycles spent in phase, latched next
   int m_srv = 0, m_t = 0, m_nxt = 0;
   bit m_yel = 0, m_valid = 0;
   int n_srv, n_t, n_nxt;
   bit n_yel, others;

   semaforo_controlador #(.T_VERDE_MIN(MINV), .T_VERDE_MAX(MAXV), .T_AMARELO(AM)) dut (
      .clock(clock), .reset(reset), .ABC(ABC),
      .VDA(VDA), .VAA(VAA), .VMA(VMA),
      .VDB(VDB), .VAB(VAB), .VMB(VMB),
      .VDC(VDC), .VAC(VAC), .VMC(VMC),
      .fase(fase)
   );

   assign dut_v = {VDA, VAA, VMA, VDB, VAB, VMB, VDC, VAC, VMC, fase};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic bit req(logic [2:0] abc, int a);
      case (a)
         0: return abc[2];
         1: return abc[1];
         default: return abc[0];
      endcase
   endfunction

   function automatic logic [10:0] expv(int srv, bit yel);
      logic [10:0] v;
      v = '0;
      for (int a = 0; a < 3; a++) begin
         if (a == srv) begin
            if (yel) v[9 - 3*a] = 1'b1;
            else     v[10 - 3*a] = 1'b1;
         end else begin
            v[8 - 3*a] = 1'b1;
         end
      end
      v[1:0] = 2'(srv);
      return v;
   endfunction

   always_comb begin
      n_srv  = m_srv;
      n_yel  = m_yel;
      n_t    = m_t + 1;
      n_nxt  = m_nxt;
      others = req(ABC, (m_srv + 1) % 3) | req(ABC, (m_srv + 2) % 3);
      if (!m_yel) begin
         if (m_t >= MINV - 1 && others && (!req(ABC, m_srv) || m_t >= MAXV - 1)) begin
            n_yel = 1'b1;
            n_t   = 0;
            n_nxt = req(ABC, (m_srv + 1) % 3) ? (m_srv + 1) % 3 : (m_srv + 2) % 3;
         end
      end else if (m_t == AM - 1) begin
         n_srv = m_nxt;
         n_yel = 1'b0;
         n_t   = 0;
      end
   end

   always @(posedge clock) begin
      if (!reset) begin
         m_srv   <= 0;
         m_yel   <= 1'b0;
         m_t     <= 0;
         m_nxt   <= 0;
         m_valid <= 1'b1;
      end else if (m_valid) begin
         m_srv <= n_srv;
         m_yel <= n_yel;
         m_t   <= n_t;
         m_nxt <= n_nxt;
      end
   end

   task automatic check(input string nm, input logic [10:0] got, input logic [10:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, exp);
      end
   endtask

   always @(negedge clock) begin
      if (m_valid) check("model", dut_v, expv(m_srv, m_yel));
   end

   task automatic lit(input string nm, input logic [10:0] exp);
      check(nm, dut_v, exp);
   endtask

   task automatic step(input logic [2:0] abc);
      @(negedge clock);
      ABC = abc;
   endtask

   // Reset for the current cycle; returns at cycle 0 with abc applied
   task automatic start(input logic [2:0] abc);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      ABC   = abc;
   endtask

   initial begin
      reset = 1'b0;
      ABC   = 3'b000;

      start(3'b000);
      lit("idle_c0", AG);
      repeat (19) step(3'b000);
      lit("idle_c19", AG);

      start(3'b010);
      repeat (3) step(3'b010);
      lit("single_c3", AG);
      step(3'b010);
      lit("single_c4", AY);
      step(3'b010);
      lit("single_c5", AY);
      step(3'b010);
      lit("single_c6", BG);
      repeat (3) step(3'b010);

      start(3'b011);
      repeat (5) step(3'b011);
      step(3'b001);
      lit("rr_c6", BG);
      repeat (3) step(3'b001);
      lit("rr_c9", BG);
      step(3'b001);
      lit("rr_c10", BY);
      step(3'b001);
      step(3'b001);
      lit("rr_c12", CG);
      repeat (2) step(3'b001);

      start(3'b110);
      repeat (7) step(3'b110);
      lit("max_c7", AG);
      step(3'b110);
      lit("max_c8", AY);
      step(3'b110);
      step(3'b110);
      lit("max_c10", BG);

      start(3'b010);
      repeat (3) step(3'b010);
      step(3'b000);
      lit("latch_c4", AY);
      step(3'b001);
      step(3'b000);
      lit("latch_c6", BG);
      repeat (4) step(3'b000);
      lit("latch_c10", BG);

      start(3'b010);
      repeat (5) step(3'b010);
      step(3'b100);
      lit("mid_c6", BG);
      repeat (3) step(3'b100);
      step(3'b100);
      lit("mid_c10", BY);
      start(3'b010);
      lit("mid_rst_c0", AG);
      repeat (3) step(3'b010);
      lit("mid_rst_c3", AG);
      step(3'b010);
      lit("mid_rst_c4", AY);
      step(3'b010);
      step(3'b010);
      lit("mid_rst_c6", BG);

      step(3'b000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/semaforo_controlador.md
Name: semaforo_controlador

Overview:
- Sequential controller for the three-approach traffic light (approaches A, B, C). It replaces the purely combinational sensor-priority decode.
- Adds timed green and yellow phases, minimum and maximum green times, and round-robin service of vehicle sensors.
- Sits between the sensor inputs and the lamp drivers. At most one approach is ever non-red.

Parameters:
- T_VERDE_MIN, default 4: minimum green duration in clock cycles (must be ≥1).
- T_VERDE_MAX, default 8: maximum green duration when another approach is waiting (must be ≥ T_VERDE_MIN).
- T_AMARELO, default 2: yellow duration in clock cycles (must be ≥1).

Ports:
- clock, in, 1: system clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-low reset.
- ABC, in, 3: vehicle sensors. ABC[2]=A, ABC[1]=B, ABC[0]=C; 1 means a vehicle is waiting.
- VDA, VAA, VMA, out, 1 each: approach A green, yellow, red.
- VDB, VAB, VMB, out, 1 each: approach B green, yellow, red.
- VDC, VAC, VMC, out, 1 each: approach C green, yellow, red.
- fase, out, 2: current served approach. 0=A, 1=B, 2=C; never 3.

Behaviour:
- States: VERDE_A, AMARELO_A, VERDE_B, AMARELO_B, VERDE_C, AMARELO_C.
- Registers:
  - cont: phase counter, width $clog2(T_VERDE_MAX+1).
  - prox: 2-bit next-approach latch.
- Reset (reset=0 at a rising edge):
  - state=VERDE_A, cont=0, prox=A.
  - Outputs: VDA=1, VMB=1, VMC=1, all others 0, fase=0.
  - Reset takes priority over every transition, including mid-yellow.
- Outputs are a Moore decode of the state register only; ABC never feeds outputs directly.
  - Each approach has exactly one of its three lamps high.
  - The served approach shows green (VERDE_x) or yellow (AMARELO_x); the other two show red.
  - fase = served approach.
- VERDE_x:
  - cont increments each cycle, saturating at T_VERDE_MAX-1.
  - outros = OR of the ABC bits of the two other approaches.
  - Exit to AMARELO_x when all hold: cont ≥ T_VERDE_MIN-1, outros=1, and either (own sensor=0 or cont ≥ T_VERDE_MAX-1).
  - On exit: cont←0, and prox← first requesting approach scanning round-robin from x+1 (A→B→C→A).
  - If outros=0, stay in VERDE_x indefinitely; the own sensor is irrelevant.
  - Green therefore lasts at least T_VERDE_MIN cycles. With competition and the own sensor held it lasts exactly T_VERDE_MAX cycles.
- AMARELO_x:
  - cont increments.
  - When cont = T_AMARELO-1, go to VERDE_prox with cont←0. Yellow lasts exactly T_AMARELO cycles.
  - ABC is ignored during yellow. prox stays fixed even if its request drops or new requests arrive.
- Simultaneous requests: resolved by round-robin order relative to the current approach. Example: from A with B and C both pending, B is served; C is served after B.
- No green-to-green transition; every change of served approach passes through yellow.
- ABC is sampled synchronously. It is assumed stable/synchronised upstream; no debouncing in this block.

Test Plan:
All cases use default parameters; cycle 0 is the first cycle with reset=1.
- Idle: reset then ABC=000 for 20 cycles → VDA=VMB=VMC=1 every cycle, fase=0, no other lamp high.
- Single request: ABC=010 from cycle 0 → VDA cycles 0–3; VAA cycles 4–5; VDB from cycle 6 with VMA=VMC=1, fase=1.
- Round robin: ABC=011 from cycle 0 → A green 4, yellow 2, then B green. Drop B (ABC=001) once B green → B green 4 cycles, yellow 2, then C green, fase=2.
- Max extension: ABC=110 held → A green exactly 8 cycles, VAA 2 cycles, then VDB.
- Yellow latch: ABC=010, then ABC=000 during AMARELO_A → VDB still asserted after yellow. ABC=001 raised during yellow → still B, not C.
- Reset mid-phase: reset=0 for one cycle during AMARELO_B → next cycle VDA=1, VMB=VMC=1, fase=0. With ABC=010 held, A is held green a fresh 4 cycles.
